// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite register controller: response codes and FSM states.
package axil_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_EXEC = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'b00,
    R_FETCH = 2'b01,
    R_DATA  = 2'b10
  } rd_state_e;

  function automatic resp_e err_to_resp(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_reg_ctrl.sv
// AXI4-Lite slave sequencing a byte-enabled 32-bit register file.
// Independent write (AW/W/B) and read (AR/R) FSMs; all outputs registered.
module axil_reg_ctrl
  import axil_pkg::*;
#(
  parameter int unsigned NumWords  = 64,
  parameter int unsigned AddrWidth = 12,
  localparam int unsigned OffsetWidth = $clog2(NumWords)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [AddrWidth-1:0]   awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [DataWidth-1:0]   wdata,
  input  logic [StrbWidth-1:0]   wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [AddrWidth-1:0]   araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [DataWidth-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [OffsetWidth-1:0] rf_wa,
  output logic [DataWidth-1:0]   rf_wd,
  output logic [StrbWidth-1:0]   rf_we,
  output logic [OffsetWidth-1:0] rf_ra,
  input  logic [DataWidth-1:0]   rf_rd
);

  localparam logic [AddrWidth:0] AddrLimit = (AddrWidth + 1)'(NumWords * 4);

  function automatic logic addr_err(input logic [AddrWidth-1:0] a);
    return {1'b0, a} >= AddrLimit;
  endfunction

  function automatic logic [OffsetWidth-1:0] addr_off(input logic [AddrWidth-1:0] a);
    return a[OffsetWidth+1:2];
  endfunction

  // Write path state
  wr_state_e              wr_state_q;
  logic                   aw_got_q, w_got_q;
  logic [AddrWidth-1:0]   awaddr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbWidth-1:0]   wstrb_q;
  logic                   awready_q, wready_q, bvalid_q;
  resp_e                  bresp_q;
  logic [OffsetWidth-1:0] rf_wa_q;
  logic [DataWidth-1:0]   rf_wd_q;
  logic [StrbWidth-1:0]   rf_we_q;

  // Read path state
  rd_state_e              rd_state_q;
  logic                   rd_err_q;
  logic                   arready_q, rvalid_q;
  resp_e                  rresp_q;
  logic [DataWidth-1:0]   rdata_q;
  logic [OffsetWidth-1:0] rf_ra_q;

  logic                   aw_hs_c, w_hs_c, aw_have_c, w_have_c, wr_err_c;
  logic [AddrWidth-1:0]   aw_addr_c;
  logic [DataWidth-1:0]   w_data_c;
  logic [StrbWidth-1:0]   w_strb_c;

  // Merge held beats with beats handshaking this cycle
  assign aw_hs_c   = awvalid && awready_q;
  assign w_hs_c    = wvalid && wready_q;
  assign aw_have_c = aw_got_q || aw_hs_c;
  assign w_have_c  = w_got_q || w_hs_c;
  assign aw_addr_c = aw_got_q ? awaddr_q : awaddr;
  assign w_data_c  = w_got_q ? wdata_q : wdata;
  assign w_strb_c  = w_got_q ? wstrb_q : wstrb;
  assign wr_err_c  = addr_err(aw_addr_c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
      rf_we_q    <= '0;
    end else begin
      rf_we_q <= '0;
      unique case (wr_state_q)
        W_IDLE: begin
          if (aw_hs_c) begin
            aw_got_q <= 1'b1;
            awaddr_q <= awaddr;
          end
          if (w_hs_c) begin
            w_got_q <= 1'b1;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
          end
          if (aw_have_c && w_have_c) begin
            wr_state_q <= W_EXEC;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            rf_we_q    <= wr_err_c ? '0 : w_strb_c;
            rf_wa_q    <= addr_off(aw_addr_c);
            rf_wd_q    <= w_data_c;
            bresp_q    <= err_to_resp(wr_err_c);
          end else begin
            awready_q <= !aw_have_c;
            wready_q  <= !w_have_c;
          end
        end
        W_EXEC: begin
          bvalid_q   <= 1'b1;
          wr_state_q <= W_RESP;
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q   <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM; rdata/rresp captured once in R_FETCH so later writes cannot disturb them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= R_IDLE;
      rd_err_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rf_ra_q    <= '0;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          if (!arready_q) begin
            arready_q <= 1'b1;
          end else if (arvalid) begin
            rf_ra_q    <= addr_off(araddr);
            rd_err_q   <= addr_err(araddr);
            arready_q  <= 1'b0;
            rd_state_q <= R_FETCH;
          end
        end
        R_FETCH: begin
          rdata_q    <= rd_err_q ? '0 : rf_rd;
          rresp_q    <= err_to_resp(rd_err_q);
          rvalid_q   <= 1'b1;
          rd_state_q <= R_DATA;
        end
        R_DATA: begin
          if (rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rf_wa   = rf_wa_q;
  assign rf_wd   = rf_wd_q;
  assign rf_we   = rf_we_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;
  assign rf_ra   = rf_ra_q;

endmodule

// File: tb/tb_axil_reg_ctrl.sv
// Directed bench for axil_reg_ctrl with a behavioural byte-enabled register file.
module tb_axil_reg_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, rf_wd, rf_rd;
  logic [3:0]  wstrb, rf_we;
  logic [1:0]  bresp, rresp;
  logic [5:0]  rf_wa, rf_ra;

  logic [31:0] mem [64];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axil_reg_ctrl #(.NumWords(64), .AddrWidth(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we), .rf_ra(rf_ra), .rf_rd(rf_rd)
  );

  // Register file model: combinational read, byte writes at the clock edge
  assign rf_rd = mem[rf_ra];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (rf_we[b]) mem[rf_wa][b*8 +: 8] <= rf_wd[b*8 +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [3:0] exp_we, input logic [1:0] exp_resp);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b0;
    chk("wr_awready", 32'(awready), 32'd1);
    chk("wr_wready", 32'(wready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_rf_we", 32'(rf_we), 32'(exp_we));
    chk("wr_rf_wa", 32'(rf_wa), 32'(a[7:2]));
    chk("wr_bvalid_early", 32'(bvalid), 32'd0);
    tick();
    chk("wr_bvalid", 32'(bvalid), 32'd1);
    chk("wr_bresp", 32'(bresp), 32'(exp_resp));
    chk("wr_we_single", 32'(rf_we), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("wr_bvalid_done", 32'(bvalid), 32'd0);
    chk("wr_awready_back", 32'(awready), 32'd1);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    chk("rd_arready", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    chk("rd_rvalid_early", 32'(rvalid), 32'd0);
    tick();
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    chk("rd_rdata", rdata, exp_d);
    chk("rd_rresp", 32'(rresp), 32'(exp_resp));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rd_rvalid_done", 32'(rvalid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset values
    #12;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("idle_awready", 32'(awready), 32'd1);
    chk("idle_wready", 32'(wready), 32'd1);
    chk("idle_arready", 32'(arready), 32'd1);

    // AW+W same cycle
    do_write(12'h004, 32'hDEADBEEF, 4'hF, 4'hF, 2'b00);
    chk("mem1", mem[1], 32'hDEADBEEF);

    // W three cycles ahead of AW
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    chk("wfirst_wready", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0;
    chk("wfirst_wready_low", 32'(wready), 32'd0);
    chk("wfirst_awready", 32'(awready), 32'd1);
    tick();
    chk("wfirst_no_we0", 32'(rf_we), 32'd0);
    tick();
    chk("wfirst_no_we1", 32'(rf_we), 32'd0);
    awaddr = 12'h008; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wfirst_we", 32'(rf_we), 32'hF);
    chk("wfirst_wa", 32'(rf_wa), 32'd2);
    chk("wfirst_wd", rf_wd, 32'h12345678);
    tick();
    chk("wfirst_we_single", 32'(rf_we), 32'd0);
    chk("wfirst_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("wfirst_bdone", 32'(bvalid), 32'd0);

    // Read word 1, stall 5 cycles while a write overwrites the same word
    araddr = 12'h004; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    chk("stall_rf_ra", 32'(rf_ra), 32'd1);
    tick();
    chk("stall_rvalid", 32'(rvalid), 32'd1);
    chk("stall_rdata0", rdata, 32'hDEADBEEF);
    chk("stall_rresp", 32'(rresp), 32'd0);
    awaddr = 12'h004; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("stall_rvalid_hold", 32'(rvalid), 32'd1);
      chk("stall_rdata_hold", rdata, 32'hDEADBEEF);
    end
    bready = 1'b0;
    chk("stall_mem_written", mem[1], 32'hCAFEF00D);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("stall_rdone", 32'(rvalid), 32'd0);

    // Out-of-range accesses
    do_write(12'h0FC, 32'h55AA55AA, 4'hF, 4'hF, 2'b00);
    do_write(12'h100, 32'hFFFFFFFF, 4'hF, 4'h0, 2'b10);
    chk("slverr_no_write", mem[0], 32'h0);
    do_read(12'h3FC, 32'h0, 2'b10);
    do_read(12'h0FC, 32'h55AA55AA, 2'b00);

    // Partial and empty strobes
    do_write(12'h014, 32'hFFFFABFF, 4'b0010, 4'b0010, 2'b00);
    do_read(12'h014, 32'h0000AB00, 2'b00);
    do_write(12'h018, 32'hFFFFFFFF, 4'b0000, 4'b0000, 2'b00);
    do_read(12'h018, 32'h0, 2'b00);

    // W_EXEC and R_FETCH to the same word return the pre-write value
    awaddr = 12'h004; awvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 12'h004; arvalid = 1'b1; bready = 1'b1; rready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("coll_we", 32'(rf_we), 32'hF);
    tick();
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_rdata_old", rdata, 32'hCAFEF00D);
    chk("coll_bvalid", 32'(bvalid), 32'd1);
    rready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    chk("coll_rdone", 32'(rvalid), 32'd0);
    do_read(12'h004, 32'h11111111, 2'b00);

    // Reset asserted while waiting in W_RESP
    awaddr = 12'h020; awvalid = 1'b1; wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("rstmid_bvalid_before", 32'(bvalid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_bvalid_async", 32'(bvalid), 32'd0);
    chk("rstmid_awready", 32'(awready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rstmid_idle_awready", 32'(awready), 32'd1);
    chk("rstmid_bvalid_after", 32'(bvalid), 32'd0);
    do_write(12'h024, 32'hA5A5A5A5, 4'hF, 4'hF, 2'b00);
    do_read(12'h024, 32'hA5A5A5A5, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
